// File: rtl/datapath_controller_if.sv
// Handshake and datapath-control bundle between the instruction controller
// and its surroundings (instruction source, status source, datapath).
interface datapath_controller_if;
  // Instruction handshake and datapath status
  logic        instr_valid;
  logic [31:0] instr;
  logic        instr_ready;
  logic [31:0] status_in;

  // Register-file addresses: Rn, Rm, Rs, Rd
  logic [3:0]  A_addr;
  logic [3:0]  B_addr;
  logic [3:0]  shift_addr;
  logic [3:0]  w_addr;

  // Datapath register enables
  logic        en_A;
  logic        en_B;
  logic        en_C;
  logic        en_status;
  logic        w_en;

  // Datapath mux selects and operation codes
  logic        sel_A;
  logic        sel_B;
  logic        sel_shift;
  logic        wb_sel;
  logic [1:0]  shift_op;
  logic [2:0]  ALU_op;

  // Shift amount and operand-2 immediate
  logic [31:0] shift_imme;
  logic [31:0] imme_data;

  // Per-instruction completion pulses
  logic        done;
  logic        skipped;
  logic        err;

  // Controller side: consumes instructions and status, drives the datapath.
  modport master (
    input  instr_valid, instr, status_in,
    output instr_ready,
    output A_addr, B_addr, shift_addr, w_addr,
    output en_A, en_B, en_C, en_status, w_en,
    output sel_A, sel_B, sel_shift, wb_sel, shift_op, ALU_op,
    output shift_imme, imme_data,
    output done, skipped, err
  );

  // Environment side: offers instructions and status, observes the controls.
  modport slave (
    output instr_valid, instr, status_in,
    input  instr_ready,
    input  A_addr, B_addr, shift_addr, w_addr,
    input  en_A, en_B, en_C, en_status, w_en,
    input  sel_A, sel_B, sel_shift, wb_sel, shift_op, ALU_op,
    input  shift_imme, imme_data,
    input  done, skipped, err
  );
endinterface

// File: rtl/datapath_controller.sv
// Multi-cycle controller for ARM data-processing instructions.
// One instruction in flight: IDLE -> DECODE -> LOAD -> EXEC -> WB -> IDLE.
// Instructions that fail their condition, or that are not supported
// data-processing forms, retire from DECODE with a skipped/err pulse.
module datapath_controller (
  input  logic                         clk,
  input  logic                         rst_n,
  datapath_controller_if.master        bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DECODE = 3'd1,
    LOAD   = 3'd2,
    EXEC   = 3'd3,
    WB     = 3'd4
  } state_t;

  // Data-processing opcodes (IR[24:21]) handled by this datapath
  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_EOR = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_ADD = 4'b0100;
  localparam logic [3:0] OP_CMP = 4'b1010;
  localparam logic [3:0] OP_ORR = 4'b1100;
  localparam logic [3:0] OP_MOV = 4'b1101;

  // ALU operation encodings
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_ORR = 3'b011;
  localparam logic [2:0] ALU_EOR = 3'b100;

  state_t      state;
  state_t      state_next;
  logic [31:0] ir;

  // Instruction fields
  logic [3:0]  cond;
  logic [1:0]  op_class;
  logic        imm_form;
  logic [3:0]  opcode;
  logic        set_flags;
  logic [3:0]  nzcv;

  assign cond      = ir[31:28];
  assign op_class  = ir[27:26];
  assign imm_form  = ir[25];
  assign opcode    = ir[24:21];
  assign set_flags = ir[20];
  assign nzcv      = bus.status_in[31:28];

  // Only the flag nibble of the status word matters to the controller.
  logic unused_status;
  assign unused_status = ^bus.status_in[27:0];

  logic accept;
  assign accept = bus.instr_valid && bus.instr_ready;

  // Decoded opcode properties
  logic        op_legal;
  logic [2:0]  dec_alu;
  logic        is_cmp;
  logic        is_mov;
  logic        cond_true;

  // Local copies of every control output, mapped onto the bus below
  logic        instr_ready;
  logic [3:0]  a_addr;
  logic [3:0]  b_addr;
  logic [3:0]  shift_addr;
  logic [3:0]  w_addr;
  logic        en_a;
  logic        en_b;
  logic        en_c;
  logic        en_status;
  logic        w_en;
  logic        sel_a;
  logic        sel_b;
  logic        sel_shift;
  logic [1:0]  shift_op;
  logic [2:0]  alu_op;
  logic [31:0] shift_imme;
  logic [31:0] imme_data;
  logic        done;
  logic        skipped;
  logic        err;

  // Evaluate an ARM condition code against the N,Z,C,V flags.
  function automatic logic cond_pass(input logic [3:0] cc, input logic [3:0] f);
    logic n, z, c, v;
    logic pass;
    n = f[3];
    z = f[2];
    c = f[1];
    v = f[0];
    case (cc)
      4'b0000: pass = z;                    // EQ
      4'b0001: pass = !z;                   // NE
      4'b0010: pass = c;                    // CS
      4'b0011: pass = !c;                   // CC
      4'b0100: pass = n;                    // MI
      4'b0101: pass = !n;                   // PL
      4'b0110: pass = v;                    // VS
      4'b0111: pass = !v;                   // VC
      4'b1000: pass = c && !z;              // HI
      4'b1001: pass = !c || z;              // LS
      4'b1010: pass = (n == v);             // GE
      4'b1011: pass = (n != v);             // LT
      4'b1100: pass = !z && (n == v);       // GT
      4'b1101: pass = z || (n != v);        // LE
      4'b1110: pass = 1'b1;                 // AL
      default: pass = 1'b0;                 // 1111 never executes
    endcase
    return pass;
  endfunction

  // Rotate a 32-bit word right by 0..31 positions.
  function automatic logic [31:0] ror32(input logic [31:0] val, input logic [4:0] amt);
    logic [63:0] doubled;
    doubled = {val, val} >> amt;
    return doubled[31:0];
  endfunction

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of process ordering.
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Instruction register, loaded on an accepted handshake
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the IR is reset because its fields feed the address and
    // immediate outputs; a known zero keeps them defined out of reset.
    if (!rst_n) begin
      ir <= '0;
    end else if (accept) begin
      ir <= bus.instr;
    end
  end

  // Opcode decode: legality and ALU operation
  always_comb begin
    op_legal = 1'b1;
    dec_alu  = ALU_ADD;
    case (opcode)
      OP_AND:  dec_alu = ALU_AND;
      OP_EOR:  dec_alu = ALU_EOR;
      OP_SUB:  dec_alu = ALU_SUB;
      OP_ADD:  dec_alu = ALU_ADD;
      OP_ORR:  dec_alu = ALU_ORR;
      OP_MOV:  dec_alu = ALU_ADD;
      OP_CMP:  dec_alu = ALU_SUB;
      default: op_legal = 1'b0;
    endcase
    if (op_class != 2'b00) begin
      op_legal = 1'b0;
    end
  end

  assign is_cmp    = (opcode == OP_CMP);
  assign is_mov    = (opcode == OP_MOV);
  assign cond_true = cond_pass(cond, nzcv);

  // Next-state logic and all control outputs
  always_comb begin
    // NOTE: every output is given a default before the case so no path
    // through this block leaves a variable unassigned (no latches).
    state_next  = state;
    instr_ready = 1'b0;
    en_a        = 1'b0;
    en_b        = 1'b0;
    en_c        = 1'b0;
    en_status   = 1'b0;
    w_en        = 1'b0;
    done        = 1'b0;
    skipped     = 1'b0;
    err         = 1'b0;
    a_addr      = '0;
    b_addr      = '0;
    shift_addr  = '0;
    w_addr      = '0;
    sel_a       = 1'b0;
    sel_b       = 1'b0;
    sel_shift   = 1'b0;
    shift_op    = '0;
    alu_op      = '0;
    shift_imme  = '0;
    imme_data   = '0;

    unique case (state)
      IDLE: begin
        instr_ready = 1'b1;
        if (bus.instr_valid) begin
          state_next = DECODE;
        end
      end
      DECODE: begin
        if (!op_legal) begin
          done       = 1'b1;
          err        = 1'b1;
          state_next = IDLE;
        end else if (!cond_true) begin
          done       = 1'b1;
          skipped    = 1'b1;
          state_next = IDLE;
        end else begin
          state_next = LOAD;
        end
      end
      LOAD: begin
        en_a       = 1'b1;
        en_b       = 1'b1;
        state_next = EXEC;
      end
      EXEC: begin
        en_c       = 1'b1;
        en_status  = set_flags || is_cmp;
        state_next = WB;
      end
      WB: begin
        w_en       = !is_cmp;
        done       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    // Operand routing is held steady from DECODE through WB; IDLE keeps
    // every address, select and immediate at zero.
    if (state != IDLE) begin
      a_addr     = ir[19:16];
      w_addr     = ir[15:12];
      shift_addr = ir[11:8];
      b_addr     = ir[3:0];
      alu_op     = dec_alu;
      sel_a      = is_mov;
      if (imm_form) begin
        sel_b     = 1'b1;
        imme_data = ror32({24'd0, ir[7:0]}, {ir[11:8], 1'b0});
      end else begin
        shift_op   = ir[6:5];
        sel_shift  = ir[4];
        shift_imme = {27'd0, ir[11:7]};
      end
    end
  end

  assign bus.instr_ready = instr_ready;
  assign bus.A_addr      = a_addr;
  assign bus.B_addr      = b_addr;
  assign bus.shift_addr  = shift_addr;
  assign bus.w_addr      = w_addr;
  assign bus.en_A        = en_a;
  assign bus.en_B        = en_b;
  assign bus.en_C        = en_c;
  assign bus.en_status   = en_status;
  assign bus.w_en        = w_en;
  assign bus.sel_A       = sel_a;
  assign bus.sel_B       = sel_b;
  assign bus.sel_shift   = sel_shift;
  assign bus.wb_sel      = 1'b0;
  assign bus.shift_op    = shift_op;
  assign bus.ALU_op      = alu_op;
  assign bus.shift_imme  = shift_imme;
  assign bus.imme_data   = imme_data;
  assign bus.done        = done;
  assign bus.skipped     = skipped;
  assign bus.err         = err;

endmodule

// File: tb/tb_datapath_controller.sv
// Scoreboard bench for datapath_controller: the stimulus thread queues the
// hand-computed expectation of each instruction, a monitor thread records the
// per-cycle control activity and compares when the controller pulses done.
module tb_datapath_controller;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  datapath_controller_if bus ();

  datapath_controller dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef enum logic [1:0] {K_NORM, K_SKIP, K_ERR} kind_t;

  typedef struct {
    kind_t       kind;
    logic [3:0]  a;
    logic [3:0]  b;
    logic [3:0]  s;
    logic [3:0]  w;
    logic [2:0]  alu;
    logic        sel_a;
    logic        sel_b;
    logic [31:0] imme;
    logic [1:0]  shift_op;
    logic        sel_shift;
    logic [4:0]  shamt;
    logic        en_st;
    logic        wr;
  } exp_t;

  exp_t sb_q[$];

  int total = 0;
  int bad   = 0;
  int stray = 0;
  int cyc   = 0;

  logic [96:0] out_vec;
  assign out_vec = {bus.A_addr, bus.B_addr, bus.shift_addr, bus.w_addr,
                    bus.en_A, bus.en_B, bus.en_C, bus.en_status, bus.w_en,
                    bus.sel_A, bus.sel_B, bus.sel_shift, bus.wb_sel,
                    bus.shift_op, bus.ALU_op, bus.shift_imme, bus.imme_data,
                    bus.done, bus.skipped, bus.err};

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  function automatic exp_t e_norm(input logic [3:0] a, input logic [3:0] b,
                                  input logic [3:0] s, input logic [3:0] w,
                                  input logic [2:0] alu, input logic sel_a,
                                  input logic sel_b, input logic [31:0] imme,
                                  input logic [1:0] shift_op, input logic sel_shift,
                                  input logic [4:0] shamt, input logic en_st,
                                  input logic wr);
    exp_t e;
    e.kind = K_NORM; e.a = a; e.b = b; e.s = s; e.w = w; e.alu = alu;
    e.sel_a = sel_a; e.sel_b = sel_b; e.imme = imme; e.shift_op = shift_op;
    e.sel_shift = sel_shift; e.shamt = shamt; e.en_st = en_st; e.wr = wr;
    return e;
  endfunction

  function automatic exp_t e_end(input kind_t k);
    exp_t e;
    e = e_norm(4'd0, 4'd0, 4'd0, 4'd0, 3'd0, 1'b0, 1'b0, 32'd0, 2'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    e.kind = k;
    return e;
  endfunction

  always @(posedge clk) cyc++;

  // Monitor: per-cycle activity masks indexed by cycles since acceptance
  bit         in_flight = 1'b0;
  int         acc_cyc;
  int         off;
  logic [7:0] m_ab, m_c, m_st, m_w, m_rdy;
  exp_t       cur;

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        in_flight = 1'b0;
      end else begin
        if (in_flight) begin
          off = cyc - acc_cyc;
          if (off < 8) begin
            m_ab[off]  = bus.en_A & bus.en_B;
            m_c[off]   = bus.en_C;
            m_st[off]  = bus.en_status;
            m_w[off]   = bus.w_en;
            m_rdy[off] = bus.instr_ready;
          end
          if (bus.done) begin
            in_flight = 1'b0;
            if (sb_q.size() == 0) begin
              check("unexpected_done", 0, 1);
            end else begin
              cur = sb_q.pop_front();
              check("retire_kind", {bus.skipped, bus.err},
                    (cur.kind == K_SKIP) ? 2'b10 : (cur.kind == K_ERR) ? 2'b01 : 2'b00);
              check("latency", off, (cur.kind == K_NORM) ? 4 : 1);
              check("en_ab_cycles", m_ab, (cur.kind == K_NORM) ? 8'h04 : 8'h00);
              check("en_c_cycles", m_c, (cur.kind == K_NORM) ? 8'h08 : 8'h00);
              check("en_status_cycles", m_st, cur.en_st ? 8'h08 : 8'h00);
              check("w_en_cycles", m_w, cur.wr ? 8'h10 : 8'h00);
              check("ready_while_busy", m_rdy, 8'h00);
              if (cur.kind == K_NORM) begin
                check("A_addr", bus.A_addr, cur.a);
                check("B_addr", bus.B_addr, cur.b);
                check("shift_addr", bus.shift_addr, cur.s);
                check("w_addr", bus.w_addr, cur.w);
                check("ALU_op", bus.ALU_op, cur.alu);
                check("selects", {bus.sel_A, bus.sel_B, bus.sel_shift, bus.wb_sel},
                      {cur.sel_a, cur.sel_b, cur.sel_shift, 1'b0});
                check("imme_data", bus.imme_data, cur.imme);
                check("shift_op", bus.shift_op, cur.shift_op);
                check("shift_imme", bus.shift_imme, {27'd0, cur.shamt});
              end
            end
          end else if (off > 8) begin
            in_flight = 1'b0;
            check("done_timeout", 0, 1);
          end
        end else if (bus.en_A | bus.en_B | bus.en_C | bus.en_status | bus.w_en |
                     bus.done | bus.skipped | bus.err) begin
          stray++;
        end
        if (!in_flight && bus.instr_valid && bus.instr_ready) begin
          in_flight = 1'b1;
          acc_cyc   = cyc;
          m_ab = '0; m_c = '0; m_st = '0; m_w = '0; m_rdy = '0;
        end
      end
    end
  end

  // Offer one instruction; optionally keep instr_valid high with a different
  // word while the controller is busy, which it must ignore.
  task automatic issue(input logic [31:0] word, input logic [31:0] status,
                       input bit push, input exp_t e, input bit hold_busy);
    int n;
    n = 0;
    while (!bus.instr_ready && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("ready_before_issue", bus.instr_ready, 1);
    bus.instr       = word;
    bus.status_in   = status;
    bus.instr_valid = 1'b1;
    if (push) sb_q.push_back(e);
    @(posedge clk);
    #1;
    if (hold_busy) begin
      bus.instr = 32'hE280F0AA;
      repeat (3) begin
        @(posedge clk);
        #1;
      end
    end
    bus.instr_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n           = 1'b0;
    bus.instr_valid = 1'b0;
    bus.instr       = '0;
    bus.status_in   = '0;
    #1;
    check("reset_outputs", out_vec, 0);
    check("reset_ready", bus.instr_ready, 1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check("idle_outputs", out_vec, 0);

    // ADD r1,r2,#5
    issue(32'hE2821005, 32'h0000_0000, 1,
          e_norm(4'd2, 4'd5, 4'd0, 4'd1, 3'b000, 0, 1, 32'd5, 2'd0, 0, 5'd0, 0, 1), 0);
    // CMP r3,r4
    issue(32'hE1530004, 32'h0000_0000, 1,
          e_norm(4'd3, 4'd4, 4'd0, 4'd0, 3'b001, 0, 0, 32'd0, 2'd0, 0, 5'd0, 1, 0), 0);
    // MOVEQ r0,#1 with Z=0, then Z=1
    issue(32'h03A00001, 32'h0000_0000, 1, e_end(K_SKIP), 0);
    issue(32'h03A00001, 32'h4000_0000, 1,
          e_norm(4'd0, 4'd1, 4'd0, 4'd0, 3'b000, 1, 1, 32'd1, 2'd0, 0, 5'd0, 0, 1), 0);
    // MOV r0,#0xFF ror 8
    issue(32'hE3A004FF, 32'h0000_0000, 1,
          e_norm(4'd0, 4'd15, 4'd4, 4'd0, 3'b000, 1, 1, 32'hFF00_0000, 2'd0, 0, 5'd0, 0, 1), 0);
    // LDR: not data-processing, and ready must return the very next cycle
    issue(32'hE5910000, 32'h0000_0000, 1, e_end(K_ERR), 0);
    @(posedge clk);
    #1;
    check("ldr_ready_next", bus.instr_ready, 1);
    // EORS r9,r10,r11,ASR #17
    issue(32'hE03A98CB, 32'h0000_0000, 1,
          e_norm(4'd10, 4'd11, 4'd8, 4'd9, 3'b100, 0, 0, 32'd0, 2'd2, 0, 5'd17, 1, 1), 0);
    // ORR r2,r3,r4,LSR r5
    issue(32'hE1832534, 32'h0000_0000, 1,
          e_norm(4'd3, 4'd4, 4'd5, 4'd2, 3'b011, 0, 0, 32'd0, 2'd1, 1, 5'd10, 0, 1), 0);
    // SUBGT r1,r1,#1: N=V=1 true, then N=1 V=0 false
    issue(32'hC2411001, 32'h9000_0000, 1,
          e_norm(4'd1, 4'd1, 4'd0, 4'd1, 3'b001, 0, 1, 32'd1, 2'd0, 0, 5'd0, 0, 1), 0);
    issue(32'hC2411001, 32'h8000_0000, 1, e_end(K_SKIP), 0);
    // ADDLS with C=1,Z=0 is false
    issue(32'h92821005, 32'h2000_0000, 1, e_end(K_SKIP), 0);
    // AND r1,r15,#0x3F ror 30
    issue(32'hE20F1F3F, 32'h0000_0000, 1,
          e_norm(4'd15, 4'd15, 4'd15, 4'd1, 3'b010, 0, 1, 32'h0000_00FC, 2'd0, 0, 5'd0, 0, 1), 0);
    // Condition 1111 never executes
    issue(32'hF2000000, 32'hF000_0000, 1, e_end(K_SKIP), 0);
    // TST is unsupported; unsupported wins over a false condition
    issue(32'hE1100000, 32'h0000_0000, 1, e_end(K_ERR), 0);
    issue(32'h01100000, 32'h0000_0000, 1, e_end(K_ERR), 0);
    // instr_valid held high while busy must be ignored
    issue(32'hE2821005, 32'h0000_0000, 1,
          e_norm(4'd2, 4'd5, 4'd0, 4'd1, 3'b000, 0, 1, 32'd5, 2'd0, 0, 5'd0, 0, 1), 1);

    // Reset during EXEC of ADD r1,r2,#5 aborts it
    issue(32'hE2821005, 32'h0000_0000, 0, e_end(K_NORM), 0);
    @(posedge clk);
    @(posedge clk);
    #2;
    check("exec_before_reset", bus.en_C, 1);
    rst_n = 1'b0;
    #1;
    check("abort_outputs", out_vec, 0);
    check("abort_ready", bus.instr_ready, 1);
    @(posedge clk);
    #1;
    check("abort_no_wb", out_vec, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("ready_after_reset", bus.instr_ready, 1);
    issue(32'hE2821005, 32'h0000_0000, 1,
          e_norm(4'd2, 4'd5, 4'd0, 4'd1, 3'b000, 0, 1, 32'd5, 2'd0, 0, 5'd0, 0, 1), 0);

    n = 0;
    while ((sb_q.size() != 0 || in_flight) && n < 50) begin
      @(posedge clk);
      n++;
    end
    repeat (3) @(posedge clk);
    check("scoreboard_drained", sb_q.size(), 0);
    check("stray_activity", stray, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
